// File: rtl/apple1_io_pkg.sv
// apple1_io_pkg: register map, control-bit indices and ASCII constants for the Apple-1 PIA I/O block
package apple1_io_pkg;
    localparam logic [1:0] REG_KBD = 2'd0, REG_KBDCR = 2'd1, REG_DSP = 2'd2, REG_DSPCR = 2'd3;
    localparam int DSPCR_OVR = 6;
    localparam logic [6:0] ASCII_CR = 7'h0D, ASCII_LF = 7'h0A, ASCII_A_LO = 7'h61, ASCII_Z_LO = 7'h7A;
    // Monitor ROM expects CR line endings and, on a stock machine, upper case only
    function automatic logic [6:0] kbd_xlate(input logic [6:0] c, input logic upcase);
        return c == ASCII_LF ? ASCII_CR :
               (upcase && c >= ASCII_A_LO && c <= ASCII_Z_LO) ? c - 7'h20 : c;
    endfunction
endpackage

// File: rtl/apple1_pia_io_if.sv
// apple1_pia_io_if: CPU-side register bus of the Apple-1 PIA I/O block
interface apple1_pia_io_if;
    logic       cs;
    logic       re;
    logic       we;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    modport master(output cs, re, we, addr, wdata, input rdata);
    modport slave(input cs, re, we, addr, wdata, output rdata);
endinterface

// File: rtl/apple1_kbd_fifo.sv
// apple1_kbd_fifo: synchronous keyboard FIFO with registered occupancy and show-ahead head
module apple1_kbd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [6:0] din,
    output logic       full,
    output logic       empty,
    output logic [6:0] head
);
    localparam int AW = $clog2(DEPTH);
    logic [6:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;
    assign full  = cnt_q == (AW+1)'(DEPTH);
    assign empty = cnt_q == '0;
    assign head  = mem_q[rd_q];
    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        wr_d    = wr_q + AW'(do_push);
        rd_d    = rd_q + AW'(do_pop);
        cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
        if (do_push) mem_q[wr_q] <= din;
    end
endmodule

// File: rtl/apple1_pia_io.sv
// apple1_pia_io: Apple-1 keyboard/display PIA registers bridging the CPU bus to byte streams
module apple1_pia_io
    import apple1_io_pkg::*;
#(
    parameter int KBD_DEPTH = 4,
    parameter int UPCASE    = 1
) (
    input  logic             clk,
    input  logic             reset,
    apple1_pia_io_if.slave   bus,
    input  logic             kbd_valid,
    input  logic [7:0]       kbd_data,
    output logic             kbd_ready,
    output logic             dsp_valid,
    output logic [6:0]       dsp_data,
    input  logic             dsp_ready
);
    logic       busy_q, busy_d;
    logic [6:0] dsp_q, dsp_d, kbdcr_q, kbdcr_d, dspcr_q, dspcr_d, head;
    logic       full, empty, push, pop, rd, wr, dsp_wr, unused_ok;
    assign unused_ok = ^{bus.wdata[7], kbd_data[7]};
    apple1_kbd_fifo #(.DEPTH(KBD_DEPTH)) u_fifo (
        .clk(clk), .reset(reset), .push(push), .pop(pop),
        .din(kbd_xlate(kbd_data[6:0], UPCASE != 0)),
        .full(full), .empty(empty), .head(head)
    );
    assign kbd_ready = !full && !reset;
    assign dsp_valid = busy_q;
    assign dsp_data  = dsp_q;
    assign bus.rdata = !bus.cs ? 8'h00 :
                       bus.addr == REG_KBD   ? (empty ? 8'h00 : {1'b1, head}) :
                       bus.addr == REG_KBDCR ? {!empty, kbdcr_q} :
                       bus.addr == REG_DSP   ? {busy_q, dsp_q} : {busy_q, dspcr_q};
    always_comb begin
        rd      = bus.cs && bus.re && !bus.we;
        wr      = bus.cs && bus.we;
        dsp_wr  = wr && bus.addr == REG_DSP;
        push    = kbd_valid && kbd_ready;
        pop     = rd && bus.addr == REG_KBD;
        kbdcr_d = (wr && bus.addr == REG_KBDCR) ? bus.wdata[6:0] : kbdcr_q;
        dsp_d   = (dsp_wr && !busy_q) ? bus.wdata[6:0] : dsp_q;
        // busy is judged pre-edge: a write landing on the handshake cycle is an overrun
        busy_d  = (dsp_wr && !busy_q) || (busy_q && !dsp_ready);
        dspcr_d = dspcr_q;
        if (wr && bus.addr == REG_DSPCR) dspcr_d = {1'b0, bus.wdata[5:0]};
        else if (dsp_wr && busy_q) dspcr_d[DSPCR_OVR] = 1'b1;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q  <= 1'b0;
            dsp_q   <= '0;
            kbdcr_q <= '0;
            dspcr_q <= '0;
        end else begin
            busy_q  <= busy_d;
            dsp_q   <= dsp_d;
            kbdcr_q <= kbdcr_d;
            dspcr_q <= dspcr_d;
        end
    end
endmodule

// File: tb/tb_apple1_pia_io.sv
// tb_apple1_pia_io: directed and random scoreboard bench against a queue-based model of the PIA
module tb_apple1_pia_io;
    localparam int DEPTH = 4;
    logic       clk = 0, reset = 1, cs = 0, re = 0, we = 0, kv = 0, dr = 0;
    logic [1:0] addr = 0;
    logic [7:0] wdata = 0, kd = 0;
    logic       kbd_ready, dsp_valid;
    logic [6:0] dsp_data;
    int         npass = 0, ntot = 0;
    logic [6:0] kq[$], dq[$];
    logic [7:0] rq[$];
    logic [8:0] sq[$];
    bit         busy = 0;
    logic [6:0] dch = 0, kcr = 0, dcr = 0;

    apple1_pia_io_if bus();
    assign bus.cs    = cs;
    assign bus.re    = re;
    assign bus.we    = we;
    assign bus.addr  = addr;
    assign bus.wdata = wdata;

    apple1_pia_io #(.KBD_DEPTH(DEPTH), .UPCASE(1)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .kbd_valid(kv), .kbd_data(kd), .kbd_ready(kbd_ready),
        .dsp_valid(dsp_valid), .dsp_data(dsp_data), .dsp_ready(dr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
        ntot++;
        if (a === e) npass++;
        else $display("FAIL %s: got %h expected %h", n, a, e);
    endtask

    function automatic logic [6:0] conv(input logic [7:0] b);
        int v = int'(b) % 128;
        if (v == 10) v = 13;
        else if (v >= 97 && v <= 122) v = v - 32;
        return 7'(v);
    endfunction

    // One clock: queue expectations from pre-edge model state, then advance the model
    task automatic cycle();
        bit full = kq.size() == DEPTH;
        bit rd = cs && re && !we;
        bit wr = cs && we;
        bit popk = rd && addr == 2'd0 && kq.size() != 0;
        logic [7:0] e;
        e = !cs ? 8'h00 :
            addr == 2'd0 ? (kq.size() != 0 ? {1'b1, kq[0]} : 8'h00) :
            addr == 2'd1 ? {kq.size() != 0, kcr} :
            addr == 2'd2 ? {busy, dch} : {busy, dcr};
        if (re) rq.push_back(e);
        if (!reset) sq.push_back({!full, busy, dch});
        @(posedge clk);
        if (reset) begin
            kq.delete(); dq.delete();
            busy = 0; dch = 0; kcr = 0; dcr = 0;
        end else begin
            bit nb = busy && !dr;
            if (popk) void'(kq.pop_front());
            if (kv && !full) kq.push_back(conv(kd));
            if (wr && addr == 2'd1) kcr = wdata[6:0];
            if (wr && addr == 2'd3) dcr = {1'b0, wdata[5:0]};
            if (wr && addr == 2'd2) begin
                if (busy) dcr[6] = 1'b1;
                else begin
                    nb = 1;
                    dch = wdata[6:0];
                    dq.push_back(wdata[6:0]);
                end
            end
            busy = nb;
        end
        #1;
    endtask

    always @(negedge clk) begin
        logic [8:0] s;
        if (sq.size() != 0) begin
            s = sq.pop_front();
            chk("kbd_ready", 8'(kbd_ready), 8'(s[8]));
            chk("dsp_valid", 8'(dsp_valid), 8'(s[7]));
            chk("dsp_data", 8'(dsp_data), 8'(s[6:0]));
        end
        if (re) begin
            if (rq.size() != 0) chk("rdata", bus.rdata, rq.pop_front());
            else begin
                ntot++;
                $display("FAIL rdata: got %h with no expectation queued", bus.rdata);
            end
        end
        if (dsp_valid === 1'b1 && dr) begin
            if (dq.size() != 0) chk("dsp_char", 8'(dsp_data), 8'(dq.pop_front()));
            else begin
                ntot++;
                $display("FAIL dsp_char: got %h with no character queued", dsp_data);
            end
        end
    end

    task automatic clr();
        cs = 0; re = 0; we = 0;
    endtask

    task automatic rdx(input logic [1:0] a, input logic [7:0] e, input string n);
        cs = 1; re = 1; we = 0; addr = a;
        #1 chk(n, bus.rdata, e);
        cycle();
        clr();
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        cs = 1; re = 0; we = 1; addr = a; wdata = d;
        cycle();
        clr();
    endtask

    task automatic key(input logic [7:0] d);
        kv = 1; kd = d;
        cycle();
        kv = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int op;
        cycle(); cycle();
        #1 chk("ready_in_reset", 8'(kbd_ready), 8'h00);
        reset = 0;
        #1 chk("ready_after_reset", 8'(kbd_ready), 8'h01);
        chk("dsp_valid_reset", 8'(dsp_valid), 8'h00);
        chk("dsp_data_reset", 8'(dsp_data), 8'h00);
        rdx(1, 8'h00, "kbdcr_reset");
        rdx(3, 8'h00, "dspcr_reset");
        rdx(0, 8'h00, "kbd_empty");

        key(8'h68); key(8'h69); key(8'h0A);
        rdx(0, 8'hC8, "kbd_h");
        rdx(0, 8'hC9, "kbd_i");
        rdx(1, 8'h80, "kbdcr_nonempty");
        rdx(0, 8'h8D, "kbd_lf_to_cr");
        rdx(1, 8'h00, "kbdcr_empty");
        key(8'hE1); key(8'h7B); key(8'h60);
        rdx(0, 8'hC1, "kbd_bit7_upcase");
        rdx(0, 8'hFB, "kbd_brace_kept");
        rdx(0, 8'hE0, "kbd_backtick_kept");

        kv = 1;
        for (int i = 0; i < 4; i++) begin
            kd = 8'h31 + 8'(i);
            cycle();
        end
        kd = 8'h35;
        #1 chk("ready_full", 8'(kbd_ready), 8'h00);
        rdx(0, 8'hB1, "kbd_pop_when_full");
        #1 chk("ready_after_pop", 8'(kbd_ready), 8'h01);
        cycle();
        kv = 0;
        for (int i = 0; i < 4; i++) rdx(0, 8'hB2 + 8'(i), "kbd_drain");
        rdx(0, 8'h00, "kbd_drained");

        kv = 1; kd = 8'h41;
        rdx(0, 8'h00, "kbd_push_read_empty");
        kv = 0;
        rdx(0, 8'hC1, "kbd_pushed_during_read");

        wr(2, 8'hC1);
        repeat (10) cycle();
        #1 chk("dsp_valid_held", 8'(dsp_valid), 8'h01);
        chk("dsp_data_held", 8'(dsp_data), 8'h41);
        rdx(2, 8'hC1, "dsp_read_busy");
        dr = 1; cycle(); dr = 0;
        #1 chk("dsp_valid_done", 8'(dsp_valid), 8'h00);
        rdx(2, 8'h41, "dsp_read_idle");

        wr(2, 8'h42); wr(2, 8'h43);
        rdx(3, 8'hC0, "dspcr_overrun");
        wr(3, 8'h00);
        rdx(3, 8'h80, "dspcr_cleared");
        rdx(2, 8'hC2, "dsp_kept_first");
        dr = 1; cycle(); dr = 0;
        wr(2, 8'h44);
        dr = 1; wr(2, 8'h45); dr = 0;
        rdx(3, 8'h40, "ovr_on_handshake_write");
        rdx(2, 8'h44, "dsp_handshake_drop");
        wr(3, 8'hFF);
        rdx(3, 8'h3F, "dspcr_low_bits");
        wr(3, 8'h00);

        key(8'h31); key(8'h32); key(8'h33);
        wr(2, 8'h50);
        reset = 1; cycle(); reset = 0;
        #1 chk("ready_after_midreset", 8'(kbd_ready), 8'h01);
        chk("dsp_valid_after_midreset", 8'(dsp_valid), 8'h00);
        rdx(1, 8'h00, "kbdcr_after_midreset");
        rdx(0, 8'h00, "kbd_after_midreset");

        repeat (3000) begin
            op    = int'($urandom_range(0, 9));
            reset = ($urandom_range(0, 299) == 0);
            kv    = ($urandom_range(0, 9) == 0);
            kd    = 8'($urandom);
            dr    = reset ? 1'b0 : ($urandom_range(0, 2) == 0);
            cs    = !reset && ($urandom_range(0, 7) != 0);
            addr  = 2'($urandom);
            wdata = 8'($urandom);
            re    = op < 4;
            we    = op >= 3 && op < 6;
            cycle();
        end

        clr(); kv = 0; dr = 0; reset = 0;
        cycle(); cycle();
        chk("rq_drained", 8'(rq.size()), 8'h00);
        chk("sq_drained", 8'(sq.size()), 8'h00);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule

// File: doc/apple1_pia_io.md
APPLE1_PIA_IO -- requirements
Module: apple1_pia_io

Interface
REQ-001 Parameter KBD_DEPTH, default 4, keyboard FIFO entries (power of two, 2..16).
REQ-002 Parameter UPCASE, default 1, convert ASCII a-z to A-Z on keyboard ingress when 1.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cs  input  1  chip select, high when CPU address is in $D010-$D013.
REQ-006 addr  input  2  register offset: 0=KBD, 1=KBDCR, 2=DSP, 3=DSPCR.
REQ-007 re  input  1  CPU read strobe, one cycle per access.
REQ-008 we  input  1  CPU write strobe, one cycle per access.
REQ-009 wdata  input  8  CPU write data.
REQ-010 rdata  output  8  read data, combinational from cs/addr and current state.
REQ-011 kbd_valid  input  1  upstream (UART RX) offers a key byte.
REQ-012 kbd_data  input  8  offered key byte.
REQ-013 kbd_ready  output  1  block accepts kbd_data this cycle.
REQ-014 dsp_valid  output  1  display character pending for downstream (UART TX).
REQ-015 dsp_data  output  7  pending display character.
REQ-016 dsp_ready  input  1  downstream accepts dsp_data this cycle.

Function
REQ-017 Keyboard push occurs when kbd_valid && kbd_ready; kbd_ready = !fifo_full (registered occupancy, not dependent on same-cycle pop).
REQ-018 Ingress conversion before storage: bit7 cleared; 0x0A -> 0x0D; if UPCASE, 0x61-0x7A -> minus 0x20; all other values unchanged.
REQ-019 Read KBD (cs&&re&&addr==0): rdata = {1'b1, head[6:0]} if non-empty, 8'h00 if empty; pops head at the edge if non-empty; read when empty has no side effect.
REQ-020 Read KBDCR: rdata = {nonempty, kbdcr[6:0]}; no side effect.
REQ-021 Write KBDCR: kbdcr[6:0] <= wdata[6:0]; bit7 not writable.
REQ-022 Write DSP when !busy: dsp_data <= wdata[6:0], busy <= 1; write when busy is dropped and sets sticky dspcr[6] (overrun).
REQ-023 Read DSP: rdata = {busy, dsp_data}; read DSPCR: rdata = {busy, dspcr[6:0]}.
REQ-024 Write DSPCR: dspcr[5:0] <= wdata[5:0], dspcr[6] <= 0.
REQ-025 dsp_valid = busy; dsp_data held stable while dsp_valid; on dsp_valid && dsp_ready busy clears at that edge (one-cycle minimum handshake).
REQ-026 DSP write in the same cycle a handshake completes is dropped (busy evaluated pre-edge) and sets overrun.
REQ-027 Full FIFO with simultaneous pop and kbd_valid: pop occurs, push not accepted (kbd_ready low); byte accepted next cycle.
REQ-028 Empty FIFO with simultaneous push and KBD read: rdata=8'h00, push stored, no pop.
REQ-029 FIFO pointers wrap modulo KBD_DEPTH; occupancy counter width clog2(KBD_DEPTH)+1.
REQ-030 re/we with cs low, or re and we both high: we takes effect, re side effects suppressed; rdata 8'h00 when cs low.

Reset
REQ-031 On reset: FIFO empty, pointers 0, kbd_ready 0 during reset and 1 on first cycle after.
REQ-032 On reset: busy 0, dsp_valid 0, dsp_data 7'h00, kbdcr 0, dspcr 0.
REQ-033 Reset mid-handshake abandons pending display char and buffered keys; no output pulse generated.

Structure
REQ-034 Package apple1_io_pkg holds register offsets, DSPCR overrun bit index, ASCII constants (CR, LF, 'a', 'z').
REQ-035 Sub-module apple1_kbd_fifo (synchronous FIFO, push/pop/full/empty/head) instantiated once.

Verification
REQ-036 Push 'h','i',LF; three KBD reads -> 8'hC8, 8'hC9, 8'h8D; KBDCR bit7 then 0.
REQ-037 Push 5 keys with KBD_DEPTH=4 -> kbd_ready low after 4th; 5th accepted one cycle after first KBD read.
REQ-038 Write DSP 8'hC1, hold dsp_ready 0 for 10 cycles -> dsp_valid high, dsp_data 7'h41, DSP read 8'hC1; assert dsp_ready -> busy 0 next cycle.
REQ-039 Write DSP twice while busy -> second dropped, DSPCR read 8'hC0; write DSPCR 8'h00 -> overrun cleared.
REQ-040 Assert reset with 3 keys buffered and busy=1 -> next cycle KBDCR 8'h00, dsp_valid 0, kbd_ready 1.
